seq_gen_tx: RTL and testbench

- Transmit side of the nibble-sequence link: emits a fixed LEN-symbol 4-bit code sequence, one symbol per CE-qualified clock, so the sequence analyzer can consume it.
- Start/abort control, optional inter-symbol gap and optional continuous looping.
- A thermometer progress word matches the analyzer's NOM encoding, so a bench can compare both ends bit-for-bit.

---
 rtl/seq_link_pkg.sv | 21 ++
 rtl/seq_sym_rom.sv | 30 +++
 rtl/seq_gen_tx.sv | 192 +++++++++++++++++++
 tb/tb_seq_gen_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_link_pkg.sv
// ---------------------------------------------------------------------------
// seq_link_pkg
// Shared definitions for the nibble-sequence link (generator and analyzer):
//   SYM_W    - symbol width in bits
//   DEF_LEN  - default sequence length in symbols
//   DEF_CODE - default 16-symbol code table, symbol 0 in the top nibble
//   seq_state_e - generator state encoding (IDLE, SEND, GAP)
// ---------------------------------------------------------------------------
package seq_link_pkg;

  localparam int SYM_W   = 4;
  localparam int DEF_LEN = 16;
  localparam logic [63:0] DEF_CODE = 64'h74142A089C32A792;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_sym_rom.sv
// ---------------------------------------------------------------------------
// seq_sym_rom
// Combinational symbol selector over a packed code table.
//   idx [3:0]     - symbol index (0 selects the most-significant nibble)
//   sym [SYM_W-1:0] - selected symbol; 0 for any index >= LEN
// Parameters: LEN (symbols in table), CODE (SYM_W*LEN-bit table).
// ---------------------------------------------------------------------------
module seq_sym_rom
  import seq_link_pkg::*;
#(
  parameter int                     LEN  = DEF_LEN,
  parameter logic [SYM_W*LEN-1:0]   CODE = DEF_CODE
) (
  input  logic [3:0]       idx,
  output logic [SYM_W-1:0] sym
);

  // Select the nibble for idx; symbol 0 sits at the top of CODE.
  always_comb begin
    sym = {SYM_W{1'b0}};
    for (int i = 0; i < LEN; i++) begin
      if (idx == 4'(i)) begin
        sym = CODE[SYM_W*(LEN-1-i) +: SYM_W];
      end else begin
        sym = sym;
      end
    end
  end

endmodule

// File: rtl/seq_gen_tx.sv
// ---------------------------------------------------------------------------
// seq_gen_tx
// Transmit side of the nibble-sequence link. Emits the LEN-symbol CODE
// sequence one symbol per CE-qualified clock, with optional GAP idle cycles
// after every symbol and optional continuous looping.
// Ports:
//   CLK, RST        - clock, asynchronous active-high reset
//   CE              - symbol-rate enable; sequencing only advances when high
//   START           - begin a pass (IDLE only, CE edges only)
//   LOOP            - restart after the last symbol (sampled when consumed)
//   ABORT           - synchronous cancel, independent of CE
//   DAT_O [3:0]     - current symbol, 0 when VLD_O is low
//   VLD_O           - DAT_O carries a sequence symbol
//   BUSY            - state is not IDLE
//   DONE            - one-CLK pulse when the last symbol is consumed
//   NOM [LEN-1:0]   - thermometer, bit i set once symbol i is consumed
// ---------------------------------------------------------------------------
module seq_gen_tx
  import seq_link_pkg::*;
#(
  parameter int                   LEN  = DEF_LEN,
  parameter logic [SYM_W*LEN-1:0] CODE = DEF_CODE,
  parameter int                   GAP  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             START,
  input  logic             LOOP,
  input  logic             ABORT,
  output logic [SYM_W-1:0] DAT_O,
  output logic             VLD_O,
  output logic             BUSY,
  output logic             DONE,
  output logic [LEN-1:0]   NOM
);

  localparam logic [3:0]       LAST_IDX = 4'(LEN - 1);
  localparam logic             HAS_GAP  = (GAP > 0);
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [SYM_W-1:0] SYM0     = CODE[SYM_W*LEN-1 -: SYM_W];

  seq_state_e       state_r, state_nxt_s;
  logic [3:0]       idx_r, idx_nxt_s;
  logic [3:0]       cnt_r, cnt_nxt_s;
  logic [SYM_W-1:0] dat_r, dat_nxt_s;
  logic             vld_r, vld_nxt_s;
  logic             done_r, done_nxt_s;
  logic [LEN-1:0]   nom_r, nom_nxt_s;
  logic [LEN-1:0]   hit_mask_s;
  logic [3:0]       rom_idx_s;
  logic [SYM_W-1:0] rom_sym_s;

  // In SEND the ROM looks one symbol ahead; in GAP idx_r already holds the
  // pending index, so the lookup depends on registers only.
  assign rom_idx_s = (state_r == ST_SEND) ? (idx_r + 4'd1) : idx_r;

  seq_sym_rom #(
    .LEN  (LEN),
    .CODE (CODE)
  ) u_rom (
    .idx (rom_idx_s),
    .sym (rom_sym_s)
  );

  // One-hot mask of the symbol being consumed, for the NOM thermometer.
  always_comb begin
    hit_mask_s = {LEN{1'b0}};
    for (int i = 0; i < LEN; i++) begin
      hit_mask_s[i] = (idx_r == 4'(i));
    end
  end

  // Next-state and next-output logic; ABORT overrides CE sequencing.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    dat_nxt_s   = dat_r;
    vld_nxt_s   = vld_r;
    nom_nxt_s   = nom_r;
    done_nxt_s  = 1'b0;
    if (ABORT) begin
      state_nxt_s = ST_IDLE;
      idx_nxt_s   = 4'd0;
      cnt_nxt_s   = 4'd0;
      dat_nxt_s   = {SYM_W{1'b0}};
      vld_nxt_s   = 1'b0;
      nom_nxt_s   = {LEN{1'b0}};
    end else if (CE) begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            state_nxt_s = ST_SEND;
            idx_nxt_s   = 4'd0;
            dat_nxt_s   = SYM0;
            vld_nxt_s   = 1'b1;
            nom_nxt_s   = {LEN{1'b0}};
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SEND: begin
          nom_nxt_s = nom_r | hit_mask_s;
          if (idx_r != LAST_IDX) begin
            // idx advances now; in GAP it is the pending symbol index.
            idx_nxt_s = idx_r + 4'd1;
            if (HAS_GAP) begin
              state_nxt_s = ST_GAP;
              cnt_nxt_s   = GAP_LOAD;
              dat_nxt_s   = {SYM_W{1'b0}};
              vld_nxt_s   = 1'b0;
            end else begin
              dat_nxt_s = rom_sym_s;
            end
          end else begin
            done_nxt_s = 1'b1;
            if (!LOOP) begin
              state_nxt_s = ST_IDLE;
              dat_nxt_s   = {SYM_W{1'b0}};
              vld_nxt_s   = 1'b0;
            end else if (!HAS_GAP) begin
              idx_nxt_s = 4'd0;
              nom_nxt_s = {LEN{1'b0}};
              dat_nxt_s = SYM0;
            end else begin
              // NOM stays full through the gap and clears on re-entry to SEND.
              state_nxt_s = ST_GAP;
              idx_nxt_s   = 4'd0;
              cnt_nxt_s   = GAP_LOAD;
              dat_nxt_s   = {SYM_W{1'b0}};
              vld_nxt_s   = 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (cnt_r != 4'd0) begin
            cnt_nxt_s = cnt_r - 4'd1;
          end else begin
            state_nxt_s = ST_SEND;
            vld_nxt_s   = 1'b1;
            dat_nxt_s   = rom_sym_s;
            // A pending index of 0 in GAP can only come from a loop wrap.
            if (idx_r == 4'd0) begin
              nom_nxt_s = {LEN{1'b0}};
            end else begin
              nom_nxt_s = nom_r;
            end
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = 4'd0;
          cnt_nxt_s   = 4'd0;
          dat_nxt_s   = {SYM_W{1'b0}};
          vld_nxt_s   = 1'b0;
          nom_nxt_s   = {LEN{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      idx_r   <= 4'd0;
      cnt_r   <= 4'd0;
      dat_r   <= {SYM_W{1'b0}};
      vld_r   <= 1'b0;
      done_r  <= 1'b0;
      nom_r   <= {LEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dat_r   <= dat_nxt_s;
      vld_r   <= vld_nxt_s;
      done_r  <= done_nxt_s;
      nom_r   <= nom_nxt_s;
    end
  end

  assign DAT_O = dat_r;
  assign VLD_O = vld_r;
  assign DONE  = done_r;
  assign NOM   = nom_r;
  assign BUSY  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_seq_gen_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_gen_tx
// Self-checking bench for seq_gen_tx: one instance with default parameters
// (GAP=0) and one with GAP=2, each driven from vector tables whose expected
// outputs are queued at drive time and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_seq_gen_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic        a_ce, a_start, a_loop, a_abort;
  logic [3:0]  a_dat;
  logic        a_vld, a_busy, a_done;
  logic [15:0] a_nom;
  logic        b_ce, b_start, b_loop, b_abort;
  logic [3:0]  b_dat;
  logic        b_vld, b_busy, b_done;
  logic [15:0] b_nom;

  always #5 CLK = ~CLK;

  seq_gen_tx u_dut (
    .CLK (CLK), .RST (RST), .CE (a_ce), .START (a_start), .LOOP (a_loop),
    .ABORT (a_abort), .DAT_O (a_dat), .VLD_O (a_vld), .BUSY (a_busy),
    .DONE (a_done), .NOM (a_nom)
  );

  seq_gen_tx #(.GAP (2)) u_dut_gap (
    .CLK (CLK), .RST (RST), .CE (b_ce), .START (b_start), .LOOP (b_loop),
    .ABORT (b_abort), .DAT_O (b_dat), .VLD_O (b_vld), .BUSY (b_busy),
    .DONE (b_done), .NOM (b_nom)
  );

  typedef struct {
    logic        sel;
    logic        start, ce, loop, abort;
    logic [3:0]  dat;
    logic        vld, busy, done;
    logic [15:0] nom;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [3:0] sym_exp [16] = '{4'h7, 4'h4, 4'h1, 4'h4, 4'h2, 4'hA, 4'h0, 4'h8,
                               4'h9, 4'hC, 4'h3, 4'h2, 4'hA, 4'h7, 4'h9, 4'h2};

  function automatic logic [15:0] therm(int k);
    logic [16:0] t;
    t = (17'd1 << k) - 17'd1;
    return t[15:0];
  endfunction

  function automatic vec_t mk(logic sel, logic start, logic ce, logic loop,
                              logic abort, logic [3:0] dat, logic vld,
                              logic busy, logic done, logic [15:0] nom);
    vec_t v;
    v.sel = sel; v.start = start; v.ce = ce; v.loop = loop; v.abort = abort;
    v.dat = dat; v.vld = vld; v.busy = busy; v.done = done; v.nom = nom;
    return v;
  endfunction

  task automatic check(string name, vec_t e);
    logic [3:0]  dat;
    logic        vld, busy, done;
    logic [15:0] nom;
    if (e.sel) begin
      dat = b_dat; vld = b_vld; busy = b_busy; done = b_done; nom = b_nom;
    end else begin
      dat = a_dat; vld = a_vld; busy = a_busy; done = a_done; nom = a_nom;
    end
    n_vec++;
    if (dat !== e.dat || vld !== e.vld || busy !== e.busy ||
        done !== e.done || nom !== e.nom) begin
      n_bad++;
      $display("FAIL %s #%0d dut%0d: got dat=%h vld=%b busy=%b done=%b nom=%h, want dat=%h vld=%b busy=%b done=%b nom=%h",
               name, n_vec, e.sel, dat, vld, busy, done, nom,
               e.dat, e.vld, e.busy, e.done, e.nom);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the next edge.
  task automatic apply(string name, vec_t v);
    vec_t e;
    if (v.sel) begin
      b_start = v.start; b_ce = v.ce; b_loop = v.loop; b_abort = v.abort;
    end else begin
      a_start = v.start; a_ce = v.ce; a_loop = v.loop; a_abort = v.abort;
    end
    sbq.push_back(v);
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    check(name, e);
  endtask

  task automatic run_table(string name);
    foreach (tbl[i]) apply(name, tbl[i]);
    tbl.delete();
  endtask

  // One GAP=2 pass; with loop set, the tail covers the wrap back to symbol 0.
  task automatic fill_gap(logic loop);
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, loop, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0000));
    for (int k = 0; k < 15; k++) begin
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, loop, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, therm(k+1)));
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, loop, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, therm(k+1)));
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, loop, 1'b0, sym_exp[k+1], 1'b1, 1'b1, 1'b0, therm(k+1)));
    end
    if (!loop) begin
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'hFFFF));
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hFFFF));
    end else begin
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 16'hFFFF));
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'hFFFF));
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0000));
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0001));
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    end
  endtask

  initial begin
    RST = 1'b1;
    a_ce = 1'b0; a_start = 1'b0; a_loop = 1'b0; a_abort = 1'b0;
    b_ce = 1'b0; b_start = 1'b0; b_loop = 1'b0; b_abort = 1'b0;
    #12;
    check("reset_a", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    check("reset_b", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Single pass, CE held high.
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0000));
    for (int k = 1; k < 16; k++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sym_exp[k], 1'b1, 1'b1, 1'b0, therm(k)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'hFFFF));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hFFFF));
    run_table("single_pass");

    // CE stalls, START while busy, ABORT after symbol A, ABORT beats START.
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h0001));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h0001));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h0001));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 16'h0003));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h0007));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 16'h000F));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 16'h001F));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h0001));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    run_table("ce_abort");

    // Continuous looping with GAP=0: symbol 2 runs straight into symbol 7.
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0000));
    for (int k = 1; k < 16; k++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, sym_exp[k], 1'b1, 1'b1, 1'b0, therm(k)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b1, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h0001));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 16'h0003));
    run_table("loop");

    // Asynchronous reset in the middle of pass 2, away from any clock edge.
    #3;
    RST = 1'b1;
    #1;
    check("async_rst", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    @(negedge CLK);
    RST = 1'b0;
    a_loop = 1'b0;
    @(posedge CLK);
    #1;
    check("post_rst", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h0001));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000));
    run_table("restart");

    // GAP=2 instance: single pass, then a looping pass through the wrap.
    fill_gap(1'b0);
    run_table("gap_pass");
    fill_gap(1'b1);
    run_table("gap_loop");

    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
